// File: rtl/gpio_scan_responder.sv
// gpio_scan_responder: chip-side end of the GPIO scan protocol.
// A 112-bit frame is shifted in MSB-first. A falling global_csb launches one
// dual-port SRAM access from the frame fields. Read data is captured and can
// be folded back into the frame's din fields with sram_load for scan-out.
module gpio_scan_responder #(
   parameter int unsigned SEL_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned WMASK_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   scan_en,
   input  logic                   scan_in,
   output logic                   scan_out,
   input  logic                   sram_load,
   input  logic                   global_csb,
   output logic [SEL_WIDTH-1:0]   sram_sel,
   output logic                   csb0,
   output logic                   web0,
   output logic [ADDR_WIDTH-1:0]  addr0,
   output logic [DATA_WIDTH-1:0]  din0,
   output logic [WMASK_WIDTH-1:0] wmask0,
   output logic                   csb1,
   output logic                   web1,
   output logic [ADDR_WIDTH-1:0]  addr1,
   output logic [DATA_WIDTH-1:0]  din1,
   output logic [WMASK_WIDTH-1:0] wmask1,
   input  logic [DATA_WIDTH-1:0]  dout0,
   input  logic [DATA_WIDTH-1:0]  dout1,
   output logic                   busy
);

   // Per-port field block, LSB first: wmask, web, csb, din, addr.
   localparam int unsigned PORT_W     = ADDR_WIDTH + DATA_WIDTH + 2 + WMASK_WIDTH;
   localparam int unsigned SCAN_WIDTH = SEL_WIDTH + 2 * PORT_W;
   localparam int unsigned WE_OFS     = WMASK_WIDTH;
   localparam int unsigned CS_OFS     = WMASK_WIDTH + 1;
   localparam int unsigned DIN_OFS    = WMASK_WIDTH + 2;
   localparam int unsigned ADDR_OFS   = WMASK_WIDTH + 2 + DATA_WIDTH;
   localparam int unsigned P0_BASE    = PORT_W;
   localparam int unsigned P1_BASE    = 0;
   localparam int unsigned SEL_BASE   = 2 * PORT_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t                  state;
   logic [SCAN_WIDTH-1:0]   shreg;
   logic [SCAN_WIDTH-1:0]   shreg_load;
   logic                    gcsb_q;
   logic                    trigger;
   logic                    rd0, rd1;
   logic                    cap_vld0, cap_vld1;
   logic [DATA_WIDTH-1:0]   cap0, cap1;
   logic                    load0, load1;
   logic [DATA_WIDTH-1:0]   load_data0, load_data1;

   logic [SEL_WIDTH-1:0]    f_sel;
   logic [ADDR_WIDTH-1:0]   f_addr0, f_addr1;
   logic [DATA_WIDTH-1:0]   f_din0, f_din1;
   logic [WMASK_WIDTH-1:0]  f_wmask0, f_wmask1;
   logic                    f_csb0, f_web0, f_csb1, f_web1;

   assign f_sel    = shreg[SEL_BASE +: SEL_WIDTH];
   assign f_addr0  = shreg[P0_BASE + ADDR_OFS +: ADDR_WIDTH];
   assign f_din0   = shreg[P0_BASE + DIN_OFS +: DATA_WIDTH];
   assign f_csb0   = shreg[P0_BASE + CS_OFS];
   assign f_web0   = shreg[P0_BASE + WE_OFS];
   assign f_wmask0 = shreg[P0_BASE +: WMASK_WIDTH];
   assign f_addr1  = shreg[P1_BASE + ADDR_OFS +: ADDR_WIDTH];
   assign f_din1   = shreg[P1_BASE + DIN_OFS +: DATA_WIDTH];
   assign f_csb1   = shreg[P1_BASE + CS_OFS];
   assign f_web1   = shreg[P1_BASE + WE_OFS];
   assign f_wmask1 = shreg[P1_BASE +: WMASK_WIDTH];

   assign scan_out = shreg[SCAN_WIDTH-1];
   assign busy     = (state != IDLE);

   // Falling strobe edge, only when idle and neither shift nor load claims the cycle.
   assign trigger = ~scan_en & ~sram_load & ~global_csb & gcsb_q & (state == IDLE);

   // Load source: during CAPTURE bypass the read data being captured this edge,
   // otherwise use the held capture; a port that did not read leaves its din field.
   always_comb begin
      load0      = (state == CAPTURE) ? rd0 : cap_vld0;
      load1      = (state == CAPTURE) ? rd1 : cap_vld1;
      load_data0 = (state == CAPTURE) ? dout0 : cap0;
      load_data1 = (state == CAPTURE) ? dout1 : cap1;
      shreg_load = shreg;
      if (load0) shreg_load[P0_BASE + DIN_OFS +: DATA_WIDTH] = load_data0;
      if (load1) shreg_load[P1_BASE + DIN_OFS +: DATA_WIDTH] = load_data1;
   end

   // Scan shift register: shift has priority over read-data load.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shreg <= '0;
      end else if (scan_en) begin
         shreg <= {shreg[SCAN_WIDTH-2:0], scan_in};
      end else if (sram_load) begin
         shreg <= shreg_load;
      end
   end

   // Access FSM: latches frame fields at trigger so later shifting cannot disturb the access.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         gcsb_q   <= 1'b1;
         sram_sel <= '0;
         csb0     <= 1'b1;
         web0     <= 1'b1;
         addr0    <= '0;
         din0     <= '0;
         wmask0   <= '0;
         csb1     <= 1'b1;
         web1     <= 1'b1;
         addr1    <= '0;
         din1     <= '0;
         wmask1   <= '0;
         rd0      <= 1'b0;
         rd1      <= 1'b0;
         cap0     <= '0;
         cap1     <= '0;
         cap_vld0 <= 1'b0;
         cap_vld1 <= 1'b0;
      end else begin
         gcsb_q <= global_csb;
         case (state)
            IDLE: begin
               if (trigger) begin
                  sram_sel <= f_sel;
                  csb0     <= f_csb0;
                  web0     <= f_web0;
                  addr0    <= f_addr0;
                  din0     <= f_din0;
                  wmask0   <= f_wmask0;
                  csb1     <= f_csb1;
                  web1     <= f_web1;
                  addr1    <= f_addr1;
                  din1     <= f_din1;
                  wmask1   <= f_wmask1;
                  rd0      <= ~f_csb0 & f_web0;
                  rd1      <= ~f_csb1 & f_web1;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               csb0  <= 1'b1;
               csb1  <= 1'b1;
               state <= CAPTURE;
            end
            CAPTURE: begin
               if (rd0) cap0 <= dout0;
               if (rd1) cap1 <= dout1;
               cap_vld0 <= rd0;
               cap_vld1 <= rd1;
               state    <= IDLE;
            end
            default: begin
               csb0  <= 1'b1;
               csb1  <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_scan_responder.sv
// tb_gpio_scan_responder: randomized and directed checks of the scan responder
// against a frame-level reference model and a behavioural dual-port SRAM.
module tb_gpio_scan_responder;

   logic         clk = 1'b0;
   logic         resetn;
   logic         scan_en, scan_in, scan_out, sram_load, global_csb;
   logic [3:0]   sram_sel;
   logic         csb0, web0, csb1, web1;
   logic [15:0]  addr0, addr1;
   logic [31:0]  din0, din1, dout0, dout1;
   logic [3:0]   wmask0, wmask1;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   logic [3:0] last_sel = '0;
   logic [31:0] mem [16];

   always #5 clk = ~clk;

   gpio_scan_responder #(.SEL_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .WMASK_WIDTH(4)) dut (
      .clk(clk), .resetn(resetn), .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
      .sram_load(sram_load), .global_csb(global_csb), .sram_sel(sram_sel),
      .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
      .csb1(csb1), .web1(web1), .addr1(addr1), .din1(din1), .wmask1(wmask1),
      .dout0(dout0), .dout1(dout1), .busy(busy)
   );

   // Behavioural dual-port SRAM (16 words, byte-lane write mask) plus access monitor.
   always @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 16; i++) mem[i] <= $urandom;
      end else begin
         if (!csb0) begin
            if (!web0) begin
               for (int b = 0; b < 4; b++)
                  if (wmask0[b]) mem[addr0[3:0]][8*b +: 8] <= din0[8*b +: 8];
            end else dout0 <= mem[addr0[3:0]];
         end
         if (!csb1) begin
            if (!web1) begin
               for (int b = 0; b < 4; b++)
                  if (wmask1[b]) mem[addr1[3:0]][8*b +: 8] <= din1[8*b +: 8];
            end else dout1 <= mem[addr1[3:0]];
         end
      end
      if (!csb0 || !csb1) begin
         acc_cnt  <= acc_cnt + 1;
         last_sel <= sram_sel;
      end
   end

   function automatic logic [111:0] pack(input logic [3:0] sel,
      input logic [15:0] a0, input logic [31:0] d0, input logic c0, input logic w0, input logic [3:0] m0,
      input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1, input logic [3:0] m1);
      return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic shift_frame(input logic [111:0] f);
      for (int i = 0; i < 112; i++) begin
         @(negedge clk);
         scan_en = 1'b1;
         scan_in = f[111-i];
      end
      @(negedge clk);
      scan_en = 1'b0;
      scan_in = 1'b0;
   endtask

   task automatic read_frame(output logic [111:0] f);
      for (int i = 0; i < 112; i++) begin
         @(negedge clk);
         f[111-i] = scan_out;
         scan_en  = 1'b1;
      end
      @(negedge clk);
      scan_en = 1'b0;
   endtask

   // Strobe for one cycle; gap extra idle cycles after CAPTURE before sram_load (gap 0 = bypass).
   task automatic run_access(input int gap, input logic do_load);
      @(negedge clk); global_csb = 1'b0;
      @(negedge clk); global_csb = 1'b1;
      @(negedge clk);
      repeat (gap) @(negedge clk);
      if (do_load) begin
         sram_load = 1'b1;
         @(negedge clk);
         sram_load = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({csb0, csb1, web0, web1, scan_out, busy} !== 6'b111100) begin
         errors++;
         $display("FAIL reset_ctl: got %b expected 111100", {csb0, csb1, web0, web1, scan_out, busy});
      end
      checks++;
      if ({sram_sel, addr0, din0, wmask0, addr1, din1, wmask1} !== '0) begin
         errors++;
         $display("FAIL reset_fields: got nonzero sel=%h a0=%h d0=%h", sram_sel, addr0, din0);
      end
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if ({csb0, csb1, busy, scan_out} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_release: got %b expected 1100", {csb0, csb1, busy, scan_out});
      end
   endtask

   task automatic test_write();
      int c;
      shift_frame(pack(4'd2, 16'd1, 32'h2, 1'b0, 1'b0, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0));
      c = acc_cnt;
      @(negedge clk); global_csb = 1'b0;
      @(negedge clk); global_csb = 1'b1;
      checks++;
      if ({csb0, web0, addr0, din0, sram_sel, wmask0, csb1, busy} !== {1'b0, 1'b0, 16'd1, 32'h2, 4'd2, 4'hF, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL write_access: got cs=%b we=%b a=%h d=%h sel=%h m=%h cs1=%b busy=%b expected 0 0 0001 00000002 2 f 1 1",
                  csb0, web0, addr0, din0, sram_sel, wmask0, csb1, busy);
      end
      @(negedge clk);
      checks++;
      if ({csb0, csb1, busy} !== 3'b111) begin
         errors++;
         $display("FAIL write_capture: got %b expected 111", {csb0, csb1, busy});
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || acc_cnt - c != 1 || mem[1] !== 32'h2) begin
         errors++;
         $display("FAIL write_done: got busy=%b accesses=%0d mem1=%h expected 0 1 00000002", busy, acc_cnt - c, mem[1]);
      end
   endtask

   task automatic test_read_load();
      logic [111:0] f, g, e;
      shift_frame(pack(4'd1, 16'd1, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 16'd2, 32'h10, 1'b0, 1'b0, 4'hF));
      run_access(0, 1'b0);
      f = pack(4'd3, 16'd1, 32'h0000FFFF, 1'b0, 1'b1, 4'hF, 16'd2, 32'h0000FFFF, 1'b0, 1'b1, 4'hF);
      e = pack(4'd3, 16'd1, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF, 16'd2, 32'h00000010, 1'b0, 1'b1, 4'hF);
      shift_frame(f);
      checks++;
      if (scan_out !== 1'b0) begin
         errors++;
         $display("FAIL msb_visible: got %b expected 0", scan_out);
      end
      run_access(0, 1'b1);
      read_frame(g);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL read_bypass_load: got %h expected %h", g, e);
      end
   endtask

   task automatic test_port1_noread();
      logic [111:0] g, e;
      logic [31:0] o0;
      o0 = mem[5];
      shift_frame(pack(4'd4, 16'd5, 32'h0000FFFF, 1'b0, 1'b1, 4'h3, 16'd6, 32'h0000FFFF, 1'b1, 1'b1, 4'hC));
      run_access(2, 1'b1);
      e = pack(4'd4, 16'd5, o0, 1'b0, 1'b1, 4'h3, 16'd6, 32'h0000FFFF, 1'b1, 1'b1, 4'hC);
      read_frame(g);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL port1_noread: got %h expected %h", g, e);
      end
   endtask

   task automatic test_hold_low();
      int c;
      c = acc_cnt;
      @(negedge clk); global_csb = 1'b0;
      repeat (5) @(negedge clk);
      global_csb = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (acc_cnt - c != 1) begin
         errors++;
         $display("FAIL hold_low: got %0d accesses expected 1", acc_cnt - c);
      end
   endtask

   task automatic test_busy_drop();
      int c;
      c = acc_cnt;
      @(negedge clk); global_csb = 1'b0;
      @(negedge clk); global_csb = 1'b1;
      @(negedge clk); global_csb = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_capture: got %b expected 1", busy);
      end
      repeat (3) @(negedge clk);
      global_csb = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (acc_cnt - c != 1) begin
         errors++;
         $display("FAIL busy_drop: got %0d accesses expected 1", acc_cnt - c);
      end
   endtask

   task automatic test_shift_priority();
      logic [111:0] f, g;
      f = pack(4'd9, 16'h1234, 32'h12345678, 1'b0, 1'b1, 4'h5, 16'h4321, 32'h87654321, 1'b0, 1'b1, 4'hA);
      sram_load = 1'b1;
      shift_frame(f);
      sram_load = 1'b0;
      read_frame(g);
      checks++;
      if (g !== f) begin
         errors++;
         $display("FAIL shift_priority: got %h expected %h", g, f);
      end
   endtask

   task automatic test_late_load();
      logic [111:0] g, e;
      logic [31:0] o0, o1;
      o0 = mem[7];
      o1 = mem[8];
      shift_frame(pack(4'd6, 16'd7, 32'h0, 1'b0, 1'b1, 4'h0, 16'd8, 32'h0, 1'b0, 1'b1, 4'h0));
      run_access(3, 1'b1);
      e = pack(4'd6, 16'd7, o0, 1'b0, 1'b1, 4'h0, 16'd8, o1, 1'b0, 1'b1, 4'h0);
      read_frame(g);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL late_load: got %h expected %h", g, e);
      end
   endtask

   task automatic test_random();
      logic [111:0] f, g, e;
      logic [3:0] sel, m0, m1;
      logic [15:0] a0, a1;
      logic [31:0] d0, d1, o0, o1, x0, x1;
      logic c0, w0, c1, w1;
      int c, gap;
      for (int it = 0; it < 24; it++) begin
         sel = 4'($urandom); a0 = 16'($urandom); a1 = 16'($urandom);
         d0 = $urandom; d1 = $urandom; m0 = 4'($urandom); m1 = 4'($urandom);
         c0 = 1'($urandom); w0 = 1'($urandom); c1 = 1'($urandom); w1 = 1'($urandom);
         gap = int'($urandom_range(0, 3));
         f = pack(sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1);
         shift_frame(f);
         o0 = mem[a0[3:0]];
         o1 = mem[a1[3:0]];
         c = acc_cnt;
         run_access(gap, 1'b1);
         checks++;
         if (acc_cnt - c != ((!c0 || !c1) ? 1 : 0) || ((!c0 || !c1) && last_sel !== sel)) begin
            errors++;
            $display("FAIL rand_access[%0d]: got n=%0d sel=%h expected n=%0d sel=%h", it, acc_cnt - c, last_sel, (!c0 || !c1) ? 1 : 0, sel);
         end
         x0 = (!c0 && w0) ? o0 : d0;
         x1 = (!c1 && w1) ? o1 : d1;
         e = pack(sel, a0, x0, c0, w0, m0, a1, x1, c1, w1, m1);
         read_frame(g);
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL rand_frame[%0d]: got %h expected %h", it, g, e);
         end
         if (!(!c0 && !w0 && !c1 && !w1 && a0[3:0] == a1[3:0])) begin
            if (!c0 && !w0) begin
               checks++;
               if (mem[a0[3:0]] !== merge(o0, d0, m0)) begin
                  errors++;
                  $display("FAIL rand_wr0[%0d]: got %h expected %h", it, mem[a0[3:0]], merge(o0, d0, m0));
               end
            end
            if (!c1 && !w1) begin
               checks++;
               if (mem[a1[3:0]] !== merge(o1, d1, m1)) begin
                  errors++;
                  $display("FAIL rand_wr1[%0d]: got %h expected %h", it, mem[a1[3:0]], merge(o1, d1, m1));
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_access();
      shift_frame(pack(4'd2, 16'd3, 32'h55, 1'b0, 1'b0, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0));
      @(negedge clk); global_csb = 1'b0;
      @(negedge clk); global_csb = 1'b1;
      checks++;
      if (csb0 !== 1'b0) begin
         errors++;
         $display("FAIL mid_access_pre: got %b expected 0", csb0);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({csb0, busy, scan_out} !== 3'b100) begin
         errors++;
         $display("FAIL mid_access_reset: got %b expected 100", {csb0, busy, scan_out});
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      resetn = 1'b0; scan_en = 1'b0; scan_in = 1'b0; sram_load = 1'b0; global_csb = 1'b1;
      test_reset();
      test_write();
      test_read_load();
      test_port1_noread();
      test_hold_low();
      test_busy_drop();
      test_shift_priority();
      test_late_load();
      test_random();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_scan_responder.md
Name: gpio_scan_responder

Overview:
- Chip-side end of the GPIO scan protocol used to exercise the SRAM macros from outside the chip.
- Receives a 112-bit serial frame MSB-first. On a global_csb strobe it issues one dual-port SRAM access from the frame fields.
- Captures the read data and, on sram_load, folds it back into the frame so the frame can be scanned out on scan_out.
- Sits between the GPIO pads / mode mux and the SRAM select/decode logic.

Parameters:
SEL_WIDTH, 4, macro select field width
ADDR_WIDTH, 16, per-port address field width
DATA_WIDTH, 32, per-port data field width
WMASK_WIDTH, 4, per-port write-mask field width
SCAN_WIDTH, SEL_WIDTH+2*(ADDR_WIDTH+DATA_WIDTH+2+WMASK_WIDTH) (=112), derived, not overridable

Ports:
clk  in  1  gpio scan/SRAM clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
scan_en  in  1  shift enable
scan_in  in  1  serial data in
scan_out  out  1  serial data out = shreg[SCAN_WIDTH-1]
sram_load  in  1  load captured read data into frame
global_csb  in  1  active-low access strobe
sram_sel  out  SEL_WIDTH  macro select to decoder
csb0, web0  out  1 each  port0 chip/write enable, active low
addr0  out  ADDR_WIDTH  port0 address
din0  out  DATA_WIDTH  port0 write data
wmask0  out  WMASK_WIDTH  port0 write mask
csb1, web1, addr1, din1, wmask1  out  as port0  port1 controls
dout0, dout1  in  DATA_WIDTH  muxed read data from the selected macro
busy  out  1  high while the FSM is not IDLE

Behaviour:
- Frame layout, MSB to LSB: sel, addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1.
- Reset (async, resetn=0):
  - shreg cleared to 0, capture registers cleared to 0, FSM to IDLE.
  - csb0=csb1=1, web0=web1=1; all other outputs 0; busy=0.
  - Reset asserted mid-access aborts the access immediately (csb outputs high the same instant).
- Shift: when scan_en=1, each edge does shreg <= {shreg[SCAN_WIDTH-2:0], scan_in}. scan_out is combinational from shreg MSB, so bit 111 is visible before the first shift.
- Priority each cycle: scan_en > sram_load > access trigger.
- Access trigger: global_csb sampled 0 while the previous sample was 1, scan_en=0, FSM in IDLE. Holding global_csb low for N cycles gives exactly one access. A trigger while busy is dropped.
- FSM states:
  - IDLE: outputs idle (csb high). On a trigger, register all frame fields onto the SRAM outputs and go to ACCESS.
  - ACCESS (1 cycle): csb0/csb1/web*/addr*/din*/wmask*/sram_sel equal to the frame fields. The SRAM samples at the end of this cycle. Next state is CAPTURE.
  - CAPTURE (1 cycle): csb0=csb1=1, other outputs held. At the end of the cycle, dout0 is registered into cap0 only if frame csb0=0 and web0=1; the same rule applies for port1 into cap1. Next state is IDLE.
- sram_load (scan_en=0):
  - Replaces the din0 field of shreg with cap0 and the din1 field with cap1; all other bits unchanged.
  - If sram_load is sampled in the CAPTURE cycle, it uses the values being captured (bypass from dout0/dout1 under the same port rule).
  - A port that did not read keeps its existing din field.
- Minimum sequence: global_csb low at edge E0 → ACCESS during E0–E1 → CAPTURE during E1–E2 → sram_load sampled at E2 is valid.
- Shifting during ACCESS or CAPTURE is allowed. Output fields were latched at trigger, so the in-flight access is not corrupted. Captures still complete.
- wmask is forwarded unmodified. Write to a port only when its csb=0 and web=0.

Test Plan:
- Reset → csb0=csb1=web0=web1=1, scan_out=0, busy=0. Assert resetn=0 during ACCESS → csb0 goes high asynchronously.
- Shift frame sel=2, addr0=1, din0=32'h00000002, csb0=0, web0=0, wmask0=F, csb1=1, then global_csb low 1 cycle → exactly one cycle with csb0=0, web0=0, addr0=1, din0=2, sram_sel=2; csb1 stays 1.
- Read frame csb0=0, web0=1, addr0=1, csb1=0, web1=1, addr1=2, din fields=32'h0000FFFF. Model returns dout0=DEADBEEF, dout1=00000010. Sequence global_csb, then 1 idle cycle, then sram_load, then 112 shifts → scan_out reproduces the frame with din0=DEADBEEF, din1=00000010, all other bits unchanged.
- global_csb held low 5 cycles → one access only. Second falling edge while busy → ignored.
- Port1 csb1=1 on a read frame → din1 field scans out unchanged (32'h0000FFFF).
- scan_en=1 together with sram_load=1 → shift wins, no load. sram_load in the CAPTURE cycle → bypass data loaded correctly.
